cnn_infer_ctrl: RTL and testbench

//  Sequences one MNIST inference: on start, gates the pixel stream from image_streamer into cnn_top.

---
 rtl/cnn_infer_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_cnn_infer_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cnn_infer_ctrl.sv
// Sequencer for one MNIST inference: gates the pixel stream into cnn_top, waits for scores, runs argmax.
// Optional cycle/stall performance counters are enabled by defining CNN_PERF_CNT_EN.
module cnn_infer_ctrl #(
   parameter int IMG_H       = 28,
   parameter int IMG_W       = 28,
   parameter int DATA_W      = 8,
   parameter int ACC_W       = 32,
   parameter int NUM_CLASSES = 10,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   output logic                             busy,
   input  logic [DATA_W-1:0]                src_pixel,
   input  logic                             src_valid,
   output logic                             src_ready,
   output logic [DATA_W-1:0]                cnn_pixel,
   output logic                             cnn_valid,
   input  logic                             cnn_ready,
   input  logic [NUM_CLASSES*ACC_W-1:0]     cnn_scores,
   input  logic                             cnn_out_valid,
   output logic [$clog2(NUM_CLASSES)-1:0]   pred_class,
   output logic signed [ACC_W-1:0]          pred_score,
   output logic                             done,
`ifdef CNN_PERF_CNT_EN
   output logic [31:0]                      perf_cycles,
   output logic [31:0]                      perf_stall,
`endif
   output logic                             err
);

   localparam int NPIX  = IMG_H * IMG_W;
   localparam int PIX_W = $clog2(NPIX + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
   localparam int IDX_W = $clog2(NUM_CLASSES);

   typedef enum logic [2:0] {S_IDLE, S_STREAM, S_WAIT_RES, S_ARGMAX, S_DONE} state_t;

   state_t                   state_q, state_d;
   logic [PIX_W-1:0]         pix_cnt_q, pix_cnt_d;
   logic [TO_W-1:0]          to_cnt_q, to_cnt_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [IDX_W-1:0]         best_idx_q, best_idx_d;
   logic signed [ACC_W-1:0]  best_q, best_d;
   logic signed [ACC_W-1:0]  scores_q [NUM_CLASSES];
   logic [IDX_W-1:0]         pred_class_q;
   logic signed [ACC_W-1:0]  pred_score_q;
   logic                     load_scores, load_pred;

   always_comb begin
      state_d     = state_q;
      pix_cnt_d   = pix_cnt_q;
      to_cnt_d    = to_cnt_q;
      idx_d       = idx_q;
      best_d      = best_q;
      best_idx_d  = best_idx_q;
      load_scores = 1'b0;
      load_pred   = 1'b0;
      err         = 1'b0;
      src_ready   = 1'b0;
      cnn_valid   = 1'b0;
      cnn_pixel   = '0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_STREAM;
               pix_cnt_d = '0;
            end
         end
         S_STREAM: begin
            src_ready = cnn_ready;
            cnn_valid = src_valid;
            cnn_pixel = src_pixel;
            // Scores arriving before the image is complete means cnn_top is out of step.
            if (cnn_out_valid) begin
               err     = 1'b1;
               state_d = S_IDLE;
            end else if (src_valid && cnn_ready) begin
               pix_cnt_d = pix_cnt_q + 1'b1;
               if (pix_cnt_q == PIX_W'(NPIX - 1)) begin
                  state_d  = S_WAIT_RES;
                  to_cnt_d = '0;
               end
            end
         end
         S_WAIT_RES: begin
            if (cnn_out_valid) begin
               load_scores = 1'b1;
               best_d      = $signed(cnn_scores[ACC_W-1:0]);
               best_idx_d  = '0;
               idx_d       = IDX_W'(1);
               state_d     = S_ARGMAX;
            end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
               err     = 1'b1;
               state_d = S_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         S_ARGMAX: begin
            // Strict compare keeps the lowest index on ties.
            if (scores_q[idx_q] > best_q) begin
               best_d     = scores_q[idx_q];
               best_idx_d = idx_q;
            end
            if (idx_q == IDX_W'(NUM_CLASSES - 1)) begin
               load_pred = 1'b1;
               state_d   = S_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         pix_cnt_q    <= '0;
         to_cnt_q     <= '0;
         idx_q        <= '0;
         pred_class_q <= '0;
         pred_score_q <= '0;
      end else begin
         state_q   <= state_d;
         pix_cnt_q <= pix_cnt_d;
         to_cnt_q  <= to_cnt_d;
         idx_q     <= idx_d;
         // Results are captured with the final compare so they are valid during the done pulse.
         if (load_pred) begin
            pred_class_q <= best_idx_d;
            pred_score_q <= best_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      if (load_scores) begin
         for (int i = 0; i < NUM_CLASSES; i++) begin
            scores_q[i] <= cnn_scores[i*ACC_W +: ACC_W];
         end
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign pred_class = pred_class_q;
   assign pred_score = pred_score_q;

`ifdef CNN_PERF_CNT_EN
   logic [31:0] perf_cycles_q, perf_stall_q;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_cycles_q <= '0;
         perf_stall_q  <= '0;
      end else if (state_q == S_IDLE) begin
         if (start) begin
            perf_cycles_q <= 32'd1;
            perf_stall_q  <= '0;
         end
      end else begin
         perf_cycles_q <= sat_inc(perf_cycles_q);
         if (state_q == S_STREAM && src_valid && !cnn_ready) begin
            perf_stall_q <= sat_inc(perf_stall_q);
         end
      end
   end

   assign perf_cycles = perf_cycles_q;
   assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_cnn_infer_ctrl.sv
// Directed bench for cnn_infer_ctrl: nominal run, backpressure, ties, timeout, reset abuse, perf counters.
module tb_cnn_infer_ctrl;
   localparam int NC   = 10;
   localparam int NPIX = 784;

   logic               clk = 1'b0;
   logic               rst, start, src_valid, src_ready, cnn_valid, cnn_ready;
   logic               cnn_out_valid, busy, done, err;
   logic [7:0]         src_pixel, cnn_pixel;
   logic [NC*32-1:0]   cnn_scores;
   logic [3:0]         pred_class;
   logic signed [31:0] pred_score;
`ifdef CNN_PERF_CNT_EN
   logic [31:0]        perf_cycles, perf_stall;
`endif

   int checks = 0, passes = 0, cyc = 0, start_cyc = 0, done_cyc = 0;
   logic signed [31:0] sv [NC];

   cnn_infer_ctrl #(.TIMEOUT_CYC(64)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy),
      .src_pixel(src_pixel), .src_valid(src_valid), .src_ready(src_ready),
      .cnn_pixel(cnn_pixel), .cnn_valid(cnn_valid), .cnn_ready(cnn_ready),
      .cnn_scores(cnn_scores), .cnn_out_valid(cnn_out_valid),
      .pred_class(pred_class), .pred_score(pred_score), .done(done),
`ifdef CNN_PERF_CNT_EN
      .perf_cycles(perf_cycles), .perf_stall(perf_stall),
`endif
      .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   function automatic logic [7:0] pix(input int k);
      return 8'(k * 37 + 11);
   endfunction

   task automatic nxt();
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_start();
      nxt();
      start = 1'b1; src_valid = 1'b0; cnn_ready = 1'b1;
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_src_ready", src_ready, 0);
      start_cyc = cyc;
   endtask

   // mode 0: always valid/ready; 1: ready toggles, valid random; 2: ready stalled 20 cycles at beat 100
   task automatic stream(input int mode, input int nbeats, input int hold);
      int k = 0, g = 0, bad = 0, stall = 0;
      while (k < nbeats && g < 6000) begin
         nxt();
         g++;
         start     = (g <= hold);
         src_pixel = pix(k);
         case (mode)
            0: begin src_valid = 1'b1; cnn_ready = 1'b1; end
            1: begin cnn_ready = g[0]; src_valid = 1'($urandom_range(0, 1)); end
            default: begin
               src_valid = 1'b1;
               cnn_ready = !(k == 100 && stall < 20);
               if (!cnn_ready) stall++;
            end
         endcase
         #1;
         if (cnn_valid !== src_valid || src_ready !== cnn_ready || busy !== 1'b1) bad++;
         if (src_valid && src_ready) begin
            if (cnn_pixel !== pix(k)) bad++;
            k++;
         end
      end
      chk("beat_count", k, nbeats);
      chk("stream_path", bad, 0);
   endtask

   task automatic after_stream(input int n);
      int leak = 0;
      for (int c = 0; c < n; c++) begin
         nxt();
         start = 1'b0; src_valid = 1'b1; cnn_ready = 1'b1; src_pixel = pix(NPIX);
         #1;
         if (src_ready !== 1'b0 || cnn_valid !== 1'b0 || cnn_pixel !== 8'd0 ||
             busy !== 1'b1 || err !== 1'b0) leak++;
      end
      chk("gate_closed", leak, 0);
   endtask

   task automatic results(input int waits, input int ecls, input int escore);
      int lat = 0;
      repeat (waits) begin nxt(); src_valid = 1'b0; end
      nxt();
      for (int i = 0; i < NC; i++) cnn_scores[i*32 +: 32] = sv[i];
      cnn_out_valid = 1'b1;
      #1;
      chk("done_early", done, 0);
      for (int c = 1; c <= 30; c++) begin
         nxt();
         cnn_out_valid = 1'b0; cnn_scores = '0;
         #1;
         if (done === 1'b1) begin lat = c; done_cyc = cyc; break; end
      end
      chk("done_latency", lat, 10);
      chk("pred_class", pred_class, ecls);
      chk("pred_score", pred_score, escore);
      nxt();
      #1;
      chk("done_pulse_end", done, 0);
      chk("busy_after_done", busy, 0);
   endtask

   initial begin
      int ec;
      rst = 1'b1; start = 1'b0; src_valid = 1'b0; cnn_ready = 1'b0;
      cnn_out_valid = 1'b0; src_pixel = '0; cnn_scores = '0;
      repeat (3) nxt();
      nxt();
      rst = 1'b0; src_valid = 1'b1; src_pixel = 8'hA5; cnn_ready = 1'b1;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_src_ready", src_ready, 0);
      chk("rst_cnn_valid", cnn_valid, 0);
      chk("rst_cnn_pixel", cnn_pixel, 0);
      chk("rst_pred_class", pred_class, 0);
      chk("rst_pred_score", pred_score, 0);

      // Nominal run; start held high early in the stream must not restart the count
      do_start();
      stream(0, NPIX, 100);
      after_stream(1);
      sv = '{5, -3, 9, 2, 0, 0, 0, 0, 0, 1};
      results(48, 2, 9);

      // Ties and negatives
      do_start();
      stream(0, NPIX, 0);
      after_stream(1);
      sv = '{-7, -7, -7, -1, -7, -7, -7, -7, -1, -7};
      results(10, 3, -1);

      // Backpressure, then timeout with no scores
      do_start();
      stream(1, NPIX, 0);
      after_stream(5);
      ec = 0;
      for (int c = 6; c <= 80; c++) begin
         nxt();
         #1;
         if (err === 1'b1) begin ec = c; break; end
      end
      chk("timeout_cycle", ec, 64);
      chk("timeout_pred_class", pred_class, 3);
      chk("timeout_pred_score", pred_score, -1);
      nxt();
      #1;
      chk("timeout_busy", busy, 0);
      chk("timeout_err_pulse", err, 0);

      // Reset in the middle of the stream with start held high
      do_start();
      stream(0, 300, 100000);
      nxt();
      rst = 1'b1; start = 1'b0;
      nxt();
      rst = 1'b0; src_valid = 1'b1; cnn_ready = 1'b1; src_pixel = 8'h3C;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_src_ready", src_ready, 0);
      chk("mid_rst_cnn_valid", cnn_valid, 0);
      chk("mid_rst_cnn_pixel", cnn_pixel, 0);
      chk("mid_rst_pred_class", pred_class, 0);
      chk("mid_rst_pred_score", pred_score, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_err", err, 0);
      do_start();
      stream(0, NPIX, 0);
      after_stream(1);
      sv = '{-3, -100, -100, -100, -100, -100, -100, -100, -100, -2};
      results(20, 9, -2);

`ifdef CNN_PERF_CNT_EN
      do_start();
      stream(2, NPIX, 0);
      after_stream(1);
      sv = '{5, -3, 9, 2, 0, 0, 0, 0, 0, 1};
      results(48, 2, 9);
      chk("perf_stall", perf_stall, 20);
      chk("perf_cycles", perf_cycles, done_cyc - start_cyc + 1);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
